multicycle_addsub: RTL and testbench
====================================

Name: multicycle_addsub

Overview:
Parametrised, multi-cycle, chunked ripple adder/subtractor. It processes CHUNK bits per clock, carrying between chunks in a register, so wide operands can be handled with a short per-cycle carry chain. The block supports add and subtract modes, a start/busy/done handshake, and registered status flags. It sits beside the combinational arithmetic library as the sequential ALU datapath element.

Parameters:
WIDTH, 16, operand/result width in bits; must be ≥2.
CHUNK, 4, bits summed per cycle; must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request operation; sampled only in IDLE or DONE
mode  input  1  0 = add, 1 = subtract; latched with start
A  input  WIDTH  operand A; latched with start
B  input  WIDTH  operand B; latched with start
carryIn  input  1  add-mode carry input; latched with start; ignored in subtract mode
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when result and flags are valid
result  output  WIDTH  registered result; holds until the next completion
carryOut  output  1  final carry; in subtract mode 1 = no borrow (A ≥ B unsigned)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset is high: state = IDLE, and busy, done, result, carryOut, overflow, zero and negative are all 0. Internal registers are also cleared.
- Operand preparation at accept:
  - Add mode: Bop = B, c0 = carryIn.
  - Subtract mode: Bop = ~B, c0 = 1, giving A + ~B + 1.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start is high at a rising edge, latch A, Bop, c0 and mode. Set chunk index k = 0 and go to RUN.
- RUN: at each edge, add chunk k using A[k*CHUNK +: CHUNK] + Bop chunk + carry register.
  - Write the chunk sum into the working register.
  - Update the carry register and increment k.
- Last chunk (k = NCHUNK-1): at the same edge, copy the working register to result and update carryOut and the flags. Go to DONE.
- DONE: lasts exactly one cycle with done = 1.
  - If start is high at the edge leaving DONE, the new operation is accepted and the FSM goes straight to RUN (back-to-back operation).
  - Otherwise the FSM goes to IDLE.
- Latency: the start edge is t0; done is high in the cycle following edge t_NCHUNK. Throughput is one operation per NCHUNK+1 cycles.
- Flags: overflow = (A[msb] == Bop[msb]) && (result[msb] != A[msb]). zero and negative are computed from the final result.
- During RUN, start is ignored and operand inputs may change freely. result and flags are not updated until completion.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- Reset mid-operation aborts the operation. No done pulse is issued, and all outputs are forced to 0.
- Degenerate CHUNK = WIDTH: NCHUNK = 1, so latency is 1 cycle.

Test Plan:
1. WIDTH=16, CHUNK=4: add 0x1234 + 0x0FFF with carryIn=0 → done 4 cycles after the start edge, result=0x2233, carryOut=0, overflow=0, zero=0, negative=0. busy is high for exactly 4 cycles.
2. Add 0xFFFF + 0x0001 → result=0x0000, carryOut=1, zero=1, overflow=0. Add 0x7FFF + 0x0000 with carryIn=1 → result=0x8000, overflow=1, negative=1.
3. Subtract 0x0005 − 0x0007 → 0xFFFE, carryOut=0, overflow=0, negative=1. Subtract 0x8000 − 0x0001 → 0x7FFF, overflow=1, carryOut=1. Subtract with carryIn=1 → same results (carryIn ignored).
4. Handshake:
   - Pulse start again during RUN with different operands → ignored; the first result is unchanged.
   - Hold start high in the DONE cycle → second operation accepted; its done arrives 5 cycles after the first done.
   - result holds its value while IDLE.
5. Assert reset asynchronously (between edges) after chunk 2 of an operation → all outputs go to 0 immediately; no done pulse. After reset is released, a fresh add 0x0001 + 0x0001 → 0x0002.
6. Parameter sweep: CHUNK=16 (latency 1), CHUNK=1 (latency 16), and WIDTH=32, CHUNK=8 adding 0xFFFFFFFF + 0x00000001 → 0x00000000, carryOut=1, latency 4. Randomised operands are compared against a reference model.

Source files
------------

// File: rtl/multicycle_addsub.sv
// multicycle_addsub: chunked multi-cycle ripple adder/subtractor with start/busy/done handshake
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, work, work_n, mask;
  logic [KW-1:0] k;
  logic [31:0] sh;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0] csum;
  logic carry, accept, last;
  always_comb begin
    accept = start && (state != RUN);
    last = k == KW'(NCHUNK - 1);
    state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    sh = 32'(CHUNK) * 32'(k);
    a_c = CHUNK'(a_r >> sh);
    b_c = CHUNK'(b_r >> sh);
    csum = {1'b0, a_c} + {1'b0, b_c} + (CHUNK + 1)'(carry);
    mask = WIDTH'({CHUNK{1'b1}}) << sh;
    work_n = (work & ~mask) | (WIDTH'(csum[CHUNK-1:0]) << sh);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      carry <= 1'b0;
      k <= '0;
      result <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else if (accept) begin
      a_r <= A;
      b_r <= mode ? ~B : B;
      carry <= mode | carryIn;
      k <= '0;
    end else if (state == RUN) begin
      work <= work_n;
      carry <= csum[CHUNK];
      k <= k + 1'b1;
      if (last) begin
        result <= work_n;
        carryOut <= csum[CHUNK];
        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (work_n[WIDTH-1] != a_r[WIDTH-1]);
        zero <= work_n == '0;
        negative <= work_n[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_multicycle_addsub.sv
// tb_multicycle_addsub: scoreboard bench for multicycle_addsub across four parameterisations
module tb_multicycle_addsub;
  typedef struct {
    int inst; int m; logic [31:0] a; logic [31:0] b; int ci;
    logic [31:0] res; int co; int ov; int z; int n;
  } vec_t;
  typedef struct {
    int inst; int t0; int lat; logic [31:0] res; int co; int ov; int z; int n;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, mode = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0] start_v = '0, busy_v, done_v, co_v, ov_v, z_v, n_v;
  logic [15:0] r0, r1, r2;
  logic [31:0] r3;
  logic [31:0] res_v [4];
  int lat_of [4] = '{4, 1, 16, 4};
  int wid_of [4] = '{16, 16, 16, 32};
  int bcnt [4] = '{0, 0, 0, 0};
  int cyc = 0, pass_cnt = 0, total = 0, t1 = 0;
  exp_t q[$];
  vec_t vt [15] = '{
    '{0, 0, 'h1234, 'h0FFF, 0, 'h2233, 0, 0, 0, 0},
    '{0, 0, 'hFFFF, 'h0001, 0, 'h0000, 1, 0, 1, 0},
    '{0, 0, 'h7FFF, 'h0000, 1, 'h8000, 0, 1, 0, 1},
    '{0, 1, 'h0005, 'h0007, 0, 'hFFFE, 0, 0, 0, 1},
    '{0, 1, 'h8000, 'h0001, 0, 'h7FFF, 1, 1, 0, 0},
    '{0, 1, 'h0005, 'h0007, 1, 'hFFFE, 0, 0, 0, 1},
    '{0, 1, 'h8000, 'h0001, 1, 'h7FFF, 1, 1, 0, 0},
    '{0, 1, 'h1234, 'h1234, 0, 'h0000, 1, 0, 1, 0},
    '{1, 0, 'h00FF, 'h0F01, 0, 'h1000, 0, 0, 0, 0},
    '{1, 1, 'h0000, 'h0001, 0, 'hFFFF, 0, 0, 0, 1},
    '{2, 0, 'hAAAA, 'h5555, 1, 'h0000, 1, 0, 1, 0},
    '{2, 1, 'h0003, 'h8000, 0, 'h8003, 0, 1, 0, 1},
    '{3, 0, 'hFFFFFFFF, 'h00000001, 0, 'h00000000, 1, 0, 1, 0},
    '{3, 0, 'h7FFFFFFF, 'h00000001, 0, 'h80000000, 0, 1, 0, 1},
    '{3, 1, 'h00000000, 'h00000000, 0, 'h00000000, 1, 0, 1, 0}
  };
  vec_t hs [3] = '{
    '{0, 0, 'h1111, 'h2222, 0, 'h3333, 0, 0, 0, 0},
    '{0, 0, 'h4000, 'h4000, 0, 'h8000, 0, 1, 0, 1},
    '{0, 0, 'h0001, 'h0001, 0, 'h0002, 0, 0, 0, 0}
  };
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign res_v[0] = {16'h0, r0};
  assign res_v[1] = {16'h0, r1};
  assign res_v[2] = {16'h0, r2};
  assign res_v[3] = r3;
  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode), .A(a[15:0]), .B(b[15:0]),
    .carryIn(cin), .busy(busy_v[0]), .done(done_v[0]), .result(r0), .carryOut(co_v[0]),
    .overflow(ov_v[0]), .zero(z_v[0]), .negative(n_v[0]));
  multicycle_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode), .A(a[15:0]), .B(b[15:0]),
    .carryIn(cin), .busy(busy_v[1]), .done(done_v[1]), .result(r1), .carryOut(co_v[1]),
    .overflow(ov_v[1]), .zero(z_v[1]), .negative(n_v[1]));
  multicycle_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode), .A(a[15:0]), .B(b[15:0]),
    .carryIn(cin), .busy(busy_v[2]), .done(done_v[2]), .result(r2), .carryOut(co_v[2]),
    .overflow(ov_v[2]), .zero(z_v[2]), .negative(n_v[2]));
  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .mode(mode), .A(a), .B(b),
    .carryIn(cin), .busy(busy_v[3]), .done(done_v[3]), .result(r3), .carryOut(co_v[3]),
    .overflow(ov_v[3]), .zero(z_v[3]), .negative(n_v[3]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic vec_t model(input int i, input int m, input logic [31:0] aa, input logic [31:0] bb, input int ci);
    vec_t v;
    logic [32:0] s;
    logic [31:0] msk, bop;
    int w;
    w = wid_of[i];
    msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bop = ((m != 0) ? ~bb : bb) & msk;
    s = {1'b0, aa & msk} + {1'b0, bop} + 33'((m != 0) ? 1 : ci);
    v.inst = i; v.m = m; v.a = aa; v.b = bb; v.ci = ci;
    v.res = s[31:0] & msk;
    v.co = int'(s[w]);
    v.ov = int'((aa[w-1] == bop[w-1]) && (v.res[w-1] != aa[w-1]));
    v.z = int'(v.res == 32'h0);
    v.n = int'(v.res[w-1]);
    return v;
  endfunction
  task automatic issue(input vec_t v);
    a = v.a; b = v.b; mode = v.m[0]; cin = v.ci[0];
    start_v[v.inst] = 1'b1;
    q.push_back('{inst: v.inst, t0: cyc + 1, lat: lat_of[v.inst], res: v.res, co: v.co, ov: v.ov, z: v.z, n: v.n});
    @(negedge clk);
    start_v[v.inst] = 1'b0;
    a = $urandom; b = $urandom; mode = 1'($urandom); cin = 1'($urandom);
  endtask
  task automatic wait_done(input int i);
    int n = 0;
    while (!done_v[i] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[i]) begin
      total++;
      $display("FAIL timeout inst %0d: done=0 after %0d cycles, expected done=1", i, n);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) bcnt[i] = 0;
      else if (busy_v[i]) bcnt[i]++;
      if (done_v[i]) begin
        exp_t e;
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_done inst %0d: got done=1 expected done=0", i);
        end else begin
          e = q.pop_front();
          chk("inst", i, e.inst);
          chk("result", res_v[i], e.res);
          chk("carryOut", 32'(co_v[i]), e.co);
          chk("overflow", 32'(ov_v[i]), e.ov);
          chk("zero", 32'(z_v[i]), e.z);
          chk("negative", 32'(n_v[i]), e.n);
          chk("latency", cyc - e.t0, e.lat);
          chk("busy_cycles", bcnt[i], e.lat);
        end
        bcnt[i] = 0;
      end
    end
  end
  initial begin
    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) chk("rst_result", res_v[i], 0);
    chk("rst_flags", 32'({busy_v, done_v, co_v, ov_v, z_v, n_v}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      issue(vt[i]);
      wait_done(vt[i].inst);
      @(negedge clk);
    end
    issue(hs[0]);
    a = 'hFFFF; b = 'hFFFF; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0);
    t1 = cyc;
    issue(hs[1]);
    wait_done(0);
    chk("b2b_gap", cyc - t1, 5);
    repeat (6) @(negedge clk);
    chk("idle_hold", res_v[0], 'h8000);
    a = 'h00FF; b = 'h0F0F; mode = 1'b0; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_result", res_v[0], 0);
    chk("abort_flags", 32'({busy_v[0], done_v[0], co_v[0], ov_v[0], z_v[0], n_v[0]}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    issue(hs[2]);
    wait_done(0);
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      vec_t v;
      v = model((j % 2 == 0) ? 0 : 3, int'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 1)));
      issue(v);
      wait_done(v.inst);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
